// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone port arbiter.
// Holds the arbiter state encoding and the Wishbone cycle type identifiers.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts consecutive unterminated strobe cycles of the owner.
// fire is combinational in the cycle the count sits at TIMEOUT_CYCLES-1 while still running.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic wb_clk,
    input  logic wb_rst_n,
    input  logic run,
    input  logic clr,
    output logic fire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire = run && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_ddr2_port_arbiter.sv
// Round-robin, burst-locked 2:1 Wishbone arbiter with a stall watchdog in front of one DDR2 port.
// Grant one cycle after request, handover in one cycle, combinational data/termination path.
module wb_ddr2_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic [31:0] wbm0_adr_i,
    input  logic [1:0]  wbm0_bte_i,
    input  logic [2:0]  wbm0_cti_i,
    input  logic        wbm0_cyc_i,
    input  logic        wbm0_stb_i,
    input  logic        wbm0_we_i,
    input  logic [31:0] wbm0_dat_i,
    input  logic [3:0]  wbm0_sel_i,
    output logic        wbm0_ack_o,
    output logic        wbm0_err_o,
    output logic        wbm0_rty_o,
    output logic [31:0] wbm0_dat_o,
    input  logic [31:0] wbm1_adr_i,
    input  logic [1:0]  wbm1_bte_i,
    input  logic [2:0]  wbm1_cti_i,
    input  logic        wbm1_cyc_i,
    input  logic        wbm1_stb_i,
    input  logic        wbm1_we_i,
    input  logic [31:0] wbm1_dat_i,
    input  logic [3:0]  wbm1_sel_i,
    output logic        wbm1_ack_o,
    output logic        wbm1_err_o,
    output logic        wbm1_rty_o,
    output logic [31:0] wbm1_dat_o,
    output logic [31:0] wbs_adr_o,
    output logic [1:0]  wbs_bte_o,
    output logic [2:0]  wbs_cti_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  wbs_sel_o,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i,
    input  logic        wbs_rty_i,
    input  logic [31:0] wbs_dat_i
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       own_q, own_d;
    logic       errp_q, errp_d;

    logic cyc_x, stb_x, cyc_y;
    logic term, granted;
    logic wd_run, wd_clr, wd_fire;

    // own_q names the master held by GNTx or ABORT; x is the owner, y the other one
    assign cyc_x   = own_q ? wbm1_cyc_i : wbm0_cyc_i;
    assign stb_x   = own_q ? wbm1_stb_i : wbm0_stb_i;
    assign cyc_y   = own_q ? wbm0_cyc_i : wbm1_cyc_i;
    assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign granted = (state_q == GNT0) || (state_q == GNT1);

    assign wd_run = granted && cyc_x && stb_x && !term;
    assign wd_clr = !wd_run || (state_d != state_q);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .run      (wd_run),
        .clr      (wd_clr),
        .fire     (wd_fire)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        case (state_q)
            IDLE: begin
                if (wbm0_cyc_i && wbm1_cyc_i) begin
                    own_d   = ~last_q;
                    state_d = last_q ? GNT0 : GNT1;
                end else if (wbm0_cyc_i) begin
                    own_d   = 1'b0;
                    state_d = GNT0;
                end else if (wbm1_cyc_i) begin
                    own_d   = 1'b1;
                    state_d = GNT1;
                end
            end
            default: begin
                if (!cyc_x) begin
                    last_d = own_q;
                    if (cyc_y) begin
                        own_d   = ~own_q;
                        state_d = own_q ? GNT0 : GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (state_q != ABORT && wd_fire) begin
                    state_d = ABORT;
                end
            end
        endcase
        errp_d = (state_d == ABORT) && (state_q != ABORT);
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            errp_q  <= errp_d;
        end
    end

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

    always_comb begin
        wbs_adr_o  = '0;
        wbs_bte_o  = '0;
        wbs_cti_o  = '0;
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_we_o   = 1'b0;
        wbs_dat_o  = '0;
        wbs_sel_o  = '0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm0_rty_o = 1'b0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        wbm1_rty_o = 1'b0;
        if (granted) begin
            if (own_q) begin
                wbs_adr_o  = wbm1_adr_i;
                wbs_bte_o  = wbm1_bte_i;
                wbs_cti_o  = wbm1_cti_i;
                wbs_cyc_o  = wbm1_cyc_i;
                wbs_stb_o  = wbm1_stb_i;
                wbs_we_o   = wbm1_we_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_sel_o  = wbm1_sel_i;
                wbm1_ack_o = wbs_ack_i;
                wbm1_err_o = wbs_err_i;
                wbm1_rty_o = wbs_rty_i;
            end else begin
                wbs_adr_o  = wbm0_adr_i;
                wbs_bte_o  = wbm0_bte_i;
                wbs_cti_o  = wbm0_cti_i;
                wbs_cyc_o  = wbm0_cyc_i;
                wbs_stb_o  = wbm0_stb_i;
                wbs_we_o   = wbm0_we_i;
                wbs_dat_o  = wbm0_dat_i;
                wbs_sel_o  = wbm0_sel_i;
                wbm0_ack_o = wbs_ack_i;
                wbm0_err_o = wbs_err_i;
                wbm0_rty_o = wbs_rty_i;
            end
        end
        // Abort error is a single pulse; the slave side stays quiet for the whole abort
        if (state_q == ABORT && errp_q) begin
            if (own_q) begin
                wbm1_err_o = 1'b1;
            end else begin
                wbm0_err_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_ddr2_port_arbiter.sv
// Randomised and directed bench for wb_ddr2_port_arbiter against a queue/integer reference model.
module tb_wb_ddr2_port_arbiter;
    import wb_arb_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [1:0]  m_bte [2];
    logic [2:0]  m_cti [2];
    logic [3:0]  m_sel [2];
    logic [1:0]  s_ack, s_err, s_rty;
    logic [31:0] wbm0_dat_o, wbm1_dat_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [1:0]  wbs_bte_o;
    logic [2:0]  wbs_cti_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic        wbs_ack_i = 0, wbs_err_i = 0, wbs_rty_i = 0;
    logic [31:0] wbs_dat_i = '0;

    int total = 0, bad = 0;
    int cyc_cnt = 0;
    bit chk_en = 0;

    // reference model state
    int md_own = -1, md_last = 1, md_cnt = 0;
    bit md_abort = 0, md_errp = 0;
    int gq[$];

    // slave behaviour
    int sl_mode = 0, sl_fix = 0, sl_wait = 0;
    bit sl_rd_en = 0;
    logic [31:0] sl_rdata = '0;

    // directed monitors
    logic [31:0] cap_dat1 = '0, mon_a0 = '0, mon_a1 = '0;
    bit ack0_seen = 0, err_cyc = 1;
    int t_stb = -1, t_err = -1, err0_n = 0, last_a0 = -1, first_a1 = -1;

    always #5 clk = ~clk;

    wb_ddr2_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .wbm0_adr_i(m_adr[0]), .wbm0_bte_i(m_bte[0]), .wbm0_cti_i(m_cti[0]),
        .wbm0_cyc_i(m_cyc[0]), .wbm0_stb_i(m_stb[0]), .wbm0_we_i(m_we[0]),
        .wbm0_dat_i(m_dat[0]), .wbm0_sel_i(m_sel[0]),
        .wbm0_ack_o(s_ack[0]), .wbm0_err_o(s_err[0]), .wbm0_rty_o(s_rty[0]), .wbm0_dat_o(wbm0_dat_o),
        .wbm1_adr_i(m_adr[1]), .wbm1_bte_i(m_bte[1]), .wbm1_cti_i(m_cti[1]),
        .wbm1_cyc_i(m_cyc[1]), .wbm1_stb_i(m_stb[1]), .wbm1_we_i(m_we[1]),
        .wbm1_dat_i(m_dat[1]), .wbm1_sel_i(m_sel[1]),
        .wbm1_ack_o(s_ack[1]), .wbm1_err_o(s_err[1]), .wbm1_rty_o(s_rty[1]), .wbm1_dat_o(wbm1_dat_o),
        .wbs_adr_o(wbs_adr_o), .wbs_bte_o(wbs_bte_o), .wbs_cti_o(wbs_cti_o), .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i), .wbs_dat_i(wbs_dat_i)
    );

    task automatic chk(input string nm, input logic [75:0] act, input logic [75:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc_cnt);
        end
    endtask

    // Model: who owns the port, whether it is aborting, and the stall count, per cycle.
    always @(posedge clk) begin
        bit t;
        cyc_cnt++;
        if (!rst_n) begin
            md_own = -1; md_abort = 0; md_last = 1; md_cnt = 0; md_errp = 0;
        end else begin
            t = wbs_ack_i | wbs_err_i | wbs_rty_i;
            md_errp = 0;
            if (md_own < 0) begin
                if (m_cyc == 2'b11) begin md_own = 1 - md_last; gq.push_back(md_own); end
                else if (m_cyc[0]) begin md_own = 0; gq.push_back(0); end
                else if (m_cyc[1]) begin md_own = 1; gq.push_back(1); end
                md_cnt = 0;
            end else if (!m_cyc[md_own]) begin
                md_last = md_own; md_abort = 0; md_cnt = 0;
                if (m_cyc[1 - md_own]) begin md_own = 1 - md_own; gq.push_back(md_own); end
                else md_own = -1;
            end else if (!md_abort) begin
                if (m_stb[md_own] && !t) begin
                    if (md_cnt == TO - 1) begin md_abort = 1; md_errp = 1; md_cnt = 0; end
                    else md_cnt++;
                end else begin
                    md_cnt = 0;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic [75:0] es;
        logic [2:0] et;
        if (chk_en) begin
            es = '0;
            if (md_own >= 0 && !md_abort)
                es = {m_adr[md_own], m_bte[md_own], m_cti[md_own], m_cyc[md_own], m_stb[md_own],
                      m_we[md_own], m_dat[md_own], m_sel[md_own]};
            chk("wbs_out", {wbs_adr_o, wbs_bte_o, wbs_cti_o, wbs_cyc_o, wbs_stb_o, wbs_we_o,
                            wbs_dat_o, wbs_sel_o}, es);
            for (int m = 0; m < 2; m++) begin
                et = 3'b000;
                if (md_own == m && !md_abort) et = {wbs_ack_i, wbs_err_i, wbs_rty_i};
                else if (md_own == m && md_abort && md_errp) et = 3'b010;
                chk(m == 0 ? "m0_term" : "m1_term", 76'({s_ack[m], s_err[m], s_rty[m]}), 76'(et));
            end
            chk("dat_bcast", 76'({wbm0_dat_o, wbm1_dat_o}), 76'({wbs_dat_i, wbs_dat_i}));
        end
    end

    always @(negedge clk) begin
        if (s_ack[1]) cap_dat1 = wbm1_dat_o;
        if (s_ack[0]) ack0_seen = 1;
        if (wbs_stb_o && t_stb < 0) t_stb = cyc_cnt;
        if (s_err[0]) begin
            err0_n++;
            if (t_err < 0) begin t_err = cyc_cnt; err_cyc = wbs_cyc_o; end
        end
        if (wbs_cyc_o && wbs_adr_o == mon_a0) last_a0 = cyc_cnt;
        if (wbs_cyc_o && wbs_adr_o == mon_a1 && first_a1 < 0) first_a1 = cyc_cnt;
    end

    function automatic int next_delay();
        int r;
        if (sl_mode != 1) return sl_fix;
        r = $urandom_range(0, 9);
        if (r == 0) return 12;
        if (r == 1) return 7;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        int r;
        forever begin
            @(posedge clk); #2;
            wbs_ack_i = 0; wbs_err_i = 0; wbs_rty_i = 0;
            wbs_dat_i = $urandom;
            if (wbs_cyc_o && wbs_stb_o) begin
                if (sl_mode != 2) begin
                    if (sl_wait == 0) begin
                        r = (sl_mode == 1) ? $urandom_range(0, 15) : 5;
                        if (r == 0) wbs_err_i = 1;
                        else if (r == 1) wbs_rty_i = 1;
                        else begin
                            wbs_ack_i = 1;
                            if (sl_rd_en) wbs_dat_i = sl_rdata;
                        end
                        sl_wait = next_delay();
                    end else begin
                        sl_wait--;
                    end
                end
            end else begin
                sl_wait = next_delay();
            end
        end
    end

    task automatic master_xfer(input int m, input int beats, input logic [31:0] adr,
                               input logic we, output int nack);
        int left, wc;
        bit done;
        nack = 0; left = beats; wc = 0; done = 0;
        @(posedge clk); #1;
        m_cyc[m] = 1; m_stb[m] = 1; m_adr[m] = adr; m_we[m] = we; m_sel[m] = 4'hF;
        m_dat[m] = $urandom; m_bte[m] = 2'b00;
        m_cti[m] = (beats == 1) ? CTI_CLASSIC : CTI_INC;
        while (!done) begin
            @(negedge clk);
            if (s_ack[m] | s_err[m] | s_rty[m]) begin
                if (s_ack[m]) nack++;
                left--; wc = 0;
                if (left == 0 || s_err[m]) done = 1;
                @(posedge clk); #1;
                if (done) begin
                    m_cyc[m] = 0; m_stb[m] = 0;
                end else begin
                    m_adr[m] = m_adr[m] + 32'd4; m_dat[m] = $urandom;
                    m_cti[m] = (left == 1) ? CTI_EOB : CTI_INC;
                end
            end else if (++wc > 400) begin
                total++; bad++;
                $display("FAIL master%0d_timeout: got no termination, expected one within 400 cycles", m);
                @(posedge clk); #1;
                m_cyc[m] = 0; m_stb[m] = 0; done = 1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL sim_hang: got no finish, expected finish within 50000 cycles");
        $fatal(1, "hang");
    end

    initial begin
        int n0, n1, alt_bad;
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_dat[m] = '0; m_bte[m] = '0; m_cti[m] = '0; m_sel[m] = '0;
        end
        repeat (3) @(posedge clk);
        #1; chk_en = 1;
        @(negedge clk);
        chk("rst_wbs_cyc", 76'(wbs_cyc_o), 76'(0));
        chk("rst_terms", 76'({s_ack, s_err, s_rty}), 76'(0));
        @(posedge clk); #1; rst_n = 1;

        // simultaneous request after reset: master 0 first, master 1 one cycle after release
        gq.delete(); mon_a0 = 32'h0000_0100; mon_a1 = 32'h0000_0200; last_a0 = -1; first_a1 = -1;
        sl_mode = 0; sl_fix = 1;
        fork
            master_xfer(0, 1, 32'h0000_0100, 1, n0);
            master_xfer(1, 1, 32'h0000_0200, 0, n1);
        join
        repeat (2) @(posedge clk);
        chk("simul_order", 76'({gq.size(), gq[0], gq[1]}), 76'({32'd2, 32'd0, 32'd1}));
        chk("handover_gap", 76'(first_a1 - last_a0), 76'(2));

        // single master read returning DEADBEEF after 3 wait cycles
        ack0_seen = 0; sl_fix = 3; sl_rd_en = 1; sl_rdata = 32'hDEADBEEF;
        master_xfer(1, 1, 32'h0000_1000, 0, n1);
        sl_rd_en = 0;
        chk("single_rdata", 76'(cap_dat1), 76'(32'hDEADBEEF));
        chk("single_ack_cnt", 76'(n1), 76'(1));
        chk("single_no_ack0", 76'(ack0_seen), 76'(0));
        repeat (2) @(posedge clk);

        // burst lock: 4 beats of master 0 while master 1 waits
        gq.delete(); sl_fix = 1;
        fork
            master_xfer(0, 4, 32'h0000_2000, 1, n0);
            begin repeat (2) @(posedge clk); master_xfer(1, 1, 32'h0000_3000, 0, n1); end
        join
        repeat (2) @(posedge clk);
        chk("burst_beats", 76'(n0), 76'(4));
        chk("burst_order", 76'({gq.size(), gq[0], gq[1]}), 76'({32'd2, 32'd0, 32'd1}));

        // round robin fairness: 10 singles each, re-requesting immediately
        gq.delete(); sl_fix = 0;
        fork
            for (int i = 0; i < 10; i++) master_xfer(0, 1, 32'h0000_4000 + i * 4, 1, n0);
            for (int i = 0; i < 10; i++) master_xfer(1, 1, 32'h0000_5000 + i * 4, 0, n1);
        join
        repeat (2) @(posedge clk);
        alt_bad = 0;
        foreach (gq[i]) if (gq[i] != i % 2) alt_bad++;
        chk("rr_count", 76'(gq.size()), 76'(20));
        chk("rr_alternate", 76'(alt_bad), 76'(0));

        // timeout: slave never answers
        gq.delete(); sl_mode = 2; t_stb = -1; t_err = -1; err0_n = 0; err_cyc = 1;
        fork
            master_xfer(0, 1, 32'h0000_6000, 0, n0);
            begin repeat (3) @(posedge clk); master_xfer(1, 1, 32'h0000_7000, 0, n1); end
        join
        repeat (2) @(posedge clk);
        chk("to_err_cycle", 76'(t_err - t_stb), 76'(TO));
        chk("to_err_pulses", 76'(err0_n), 76'(1));
        chk("to_cyc_low", 76'(err_cyc), 76'(0));
        chk("to_then_m1", 76'({gq.size(), gq[0], gq[1]}), 76'({32'd2, 32'd0, 32'd1}));

        // mid-burst reset: last is 0 beforehand, so only a real reset makes master 0 win the tie
        sl_mode = 0; sl_fix = 0;
        master_xfer(0, 1, 32'h0000_8000, 1, n0);
        @(posedge clk); #1;
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 32'h0000_9000; m_cti[0] = CTI_INC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 32'h0000_A000; m_cti[1] = CTI_CLASSIC;
        @(posedge clk); #1; rst_n = 1;
        @(negedge clk);
        chk("mrst_cyc_low", 76'(wbs_cyc_o), 76'(0));
        @(negedge clk);
        chk("mrst_first_m0", 76'({wbs_cyc_o, wbs_adr_o}), 76'({1'b1, 32'h0000_9000}));
        @(posedge clk); #1; m_cyc[0] = 0; m_stb[0] = 0;
        repeat (3) @(posedge clk);
        #1; m_cyc[1] = 0; m_stb[1] = 0;
        repeat (2) @(posedge clk);

        // random traffic with random terminations and occasional stalls
        sl_mode = 1;
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                master_xfer(0, $urandom_range(1, 4), $urandom & 32'hFFFF_FFFC, 1'($urandom), n0);
            end
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                master_xfer(1, $urandom_range(1, 4), $urandom & 32'hFFFF_FFFC, 1'($urandom), n1);
            end
        join
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_ddr2_port_arbiter.md
# wb_ddr2_port_arbiter

Two-master to one-slave Wishbone B3 arbiter placed directly upstream of one DDR2 controller Wishbone port. It lets a sixth and further masters share one of the five controller ports. Grant is round-robin and burst-locked. A watchdog terminates stalled accesses with an error so that a hung master cannot lock the port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of consecutive cycles the granted master may hold stb without receiving a slave ack/err/rty before the arbiter aborts. Range 1..65535.
- CNT_W, 16: width of the watchdog counter. Must be large enough to hold TIMEOUT_CYCLES.

Ports:
- wb_clk  in  1  clock for everything in the block.
- wb_rst_n  in  1  reset: synchronous, active-low, sampled on the rising edge of wb_clk.
- wbm0_adr_i/wbm1_adr_i  in  32  master address.
- wbm0_bte_i/wbm1_bte_i  in  2  burst type extension.
- wbm0_cti_i/wbm1_cti_i  in  3  cycle type identifier.
- wbm0_cyc_i/wbm1_cyc_i, wbm0_stb_i/wbm1_stb_i, wbm0_we_i/wbm1_we_i  in  1  master bus controls.
- wbm0_dat_i/wbm1_dat_i  in  32  write data.
- wbm0_sel_i/wbm1_sel_i  in  4  byte selects.
- wbm0_ack_o/wbm1_ack_o, wbm0_err_o/wbm1_err_o, wbm0_rty_o/wbm1_rty_o  out  1  master terminations.
- wbm0_dat_o/wbm1_dat_o  out  32  read data.
- wbs_adr_o 32, wbs_bte_o 2, wbs_cti_o 3, wbs_cyc_o 1, wbs_stb_o 1, wbs_we_o 1, wbs_dat_o 32, wbs_sel_o 4  out  slave-side copies of the granted master's signals.
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  1  slave terminations.
- wbs_dat_i  in  32  slave read data.

## Operation
- State register `state`:
  - IDLE.
  - GNT0 and GNT1: master 0 or master 1 owns the slave.
  - ABORT: a timeout fired.
- Register `last`: the master served most recently. Reset value is 1, so master 0 wins the first tie.
- IDLE:
  - If exactly one cyc is high, go to the GNT state of that master.
  - If both cyc are high, grant the master that is not `last`.
- GNTx:
  - The slave outputs mirror master x combinationally. wbs_cyc_o is wbmx_cyc_i; wbs_stb_o is wbmx_stb_i.
  - Terminations from the slave route only to master x. The other master's ack, err and rty are 0.
  - wbs_dat_i is broadcast to both masters' dat_o.
  - The grant is held for as long as wbmx_cyc_i stays high. This covers incrementing bursts (cti 3'b010 through 3'b111) and back-to-back classic cycles.
- Release: in the cycle where the granted master's cyc_i is 0, set `last` to x.
  - If the other master's cyc is high in that cycle, go directly to its GNT state (one-cycle handover, no IDLE cycle).
  - Otherwise go to IDLE.
- Watchdog:
  - Counts while in GNTx with stb high and no slave termination.
  - Clears on any slave termination, when stb is low, or on a state change.
  - When the count reaches TIMEOUT_CYCLES - 1 with no termination, the next cycle enters ABORT.
- ABORT:
  - wbs_cyc_o and wbs_stb_o are forced to 0.
  - wbmx_err_o is 1 for exactly the first ABORT cycle.
  - Stay in ABORT until wbmx_cyc_i is 0, then set `last` to x and apply the release rules.
- A slave termination that arrives in the same cycle the watchdog would fire takes priority: the termination is passed to the master and no abort occurs.

## Timing
- Reset (wb_rst_n = 0 at an edge):
  - Next cycle: state is IDLE, `last` is 1, counter is 0.
  - All wbs_* outputs are 0. All wbm*_ack/err/rty are 0. wbm*_dat_o follow wbs_dat_i.
- Reset in the middle of a transaction drops wbs_cyc_o in the following cycle. No termination is generated to the master.
- Grant latency: a cyc rising edge sampled in IDLE at edge N gives wbs_cyc_o high from cycle N+1.
- Handover latency between masters: 1 cycle.
- The data path is combinational. There is no added latency on terminations.
- When TIMEOUT_CYCLES = 1, an access with no termination in its first stb cycle aborts on the next cycle.

## Structure
- Shared package wb_arb_pkg:
  - state enum {IDLE, GNT0, GNT1, ABORT}.
  - CTI constants CTI_CLASSIC = 3'b000, CTI_INC = 3'b010, CTI_EOB = 3'b111.
- One sub-module, wb_arb_watchdog. It contains the counter, clear and fire logic. It is parameterised by TIMEOUT_CYCLES and CNT_W and has ports wb_clk, wb_rst_n, run, clr, fire.

## Test plan
- Single master: wbm1 does a classic read of 0x0000_1000; the slave acks after 3 cycles with 0xDEADBEEF. Required: wbm1_dat_o = 0xDEADBEEF with wbm1_ack_o = 1, and wbm0_ack_o stays 0 throughout.
- Simultaneous request after reset: both cyc rise in the same cycle. Required: master 0 is granted first. After master 0 drops cyc, master 1 is granted in the very next cycle.
- Burst lock: master 0 issues a 4-beat incrementing burst (cti 010, 010, 010, 111) while master 1 holds cyc. Required: all 4 beats reach the slave without interruption, then master 1 is granted.
- Round-robin fairness: both masters issue 10 back-to-back single cycles each, re-raising cyc immediately after each one. Required: grants strictly alternate 0,1,0,1,…
- Timeout: TIMEOUT_CYCLES = 8 and the slave never acks. Required: wbm0_err_o pulses for 1 cycle on the 9th cycle after stb rises, wbs_cyc_o is 0 in that cycle, and master 1 is granted after master 0 drops cyc.
- Mid-burst reset: assert wb_rst_n = 0 during beat 2 of a burst. Required: the next cycle shows wbs_cyc_o = 0 and state = IDLE, and the first grant after reset goes to master 0.
